// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: datapath width, ALU operation codes and the
// decode-to-execute control bundle carried across the ID/EX register.
package id_ex_stage_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    logic [2:0] alu_ctrl;
  } ctrl_de_t;

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detection between the load sitting in EX and the
// instruction being decoded; kept separate so forwarding can grow here.
module hazard_unit
  import id_ex_stage_pkg::*;
(
  input  logic            i_valid_e,
  input  logic            i_result_src_e,
  input  logic [REGW-1:0] i_rd_e,
  input  logic [REGW-1:0] i_rs1_d,
  input  logic [REGW-1:0] i_rs2_d,
  output logic            o_lw_stall
);

  logic w_rd_nonzero;
  logic w_src_match;

  // x0 is hard-wired to zero, so a load into it can never create a hazard.
  assign w_rd_nonzero = (i_rd_e != '0);
  assign w_src_match  = (i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d);
  assign o_lw_stall   = i_valid_e && i_result_src_e && w_rd_nonzero && w_src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch-flush bubble
// insertion, plus a saturating count of bubbles inserted.
module id_ex_stage
#(
  parameter int XLEN = id_ex_stage_pkg::XLEN,
  parameter int CNTW = 16
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            reg_write_d,
  input  logic            alu_src_d,
  input  logic            mem_write_d,
  input  logic            result_src_d,
  input  logic            branch_d,
  input  logic [2:0]      alu_ctrl_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] imm_ext_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic            flush_e,
  output logic            reg_write_e,
  output logic            alu_src_e,
  output logic            mem_write_e,
  output logic            result_src_e,
  output logic            branch_e,
  output logic            valid_e,
  output logic [2:0]      alu_ctrl_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc_plus4_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic [CNTW-1:0] bubble_cnt
);

  import id_ex_stage_pkg::*;

  ctrl_de_t        w_ctrl_d;
  logic            w_lw_stall;
  logic            w_bubble;

  ctrl_de_t        r_ctrl;
  logic            r_valid;
  logic [XLEN-1:0] r_rd1;
  logic [XLEN-1:0] r_rd2;
  logic [XLEN-1:0] r_imm_ext;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [CNTW-1:0] r_bubble_cnt;

  assign w_ctrl_d = '{
    reg_write:  reg_write_d,
    alu_src:    alu_src_d,
    mem_write:  mem_write_d,
    result_src: result_src_d,
    branch:     branch_d,
    alu_ctrl:   alu_ctrl_d
  };

  hazard_unit u_hazard (
    .i_valid_e      (r_valid),
    .i_result_src_e (r_ctrl.result_src),
    .i_rd_e         (r_rd),
    .i_rs1_d        (rs1_d),
    .i_rs2_d        (rs2_d),
    .o_lw_stall     (w_lw_stall)
  );

  // A flush and a stall on the same edge collapse into a single bubble.
  assign w_bubble = flush_e || w_lw_stall;

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_ctrl     <= '0;
      r_valid    <= 1'b0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm_ext  <= '0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else begin
      r_ctrl     <= w_ctrl_d;
      r_valid    <= 1'b1;
      r_rd1      <= rd1_d;
      r_rd2      <= rd2_d;
      r_imm_ext  <= imm_ext_d;
      r_pc       <= pc_d;
      r_pc_plus4 <= pc_plus4_d;
      r_rs1      <= rs1_d;
      r_rs2      <= rs2_d;
      r_rd       <= rd_d;
    end
  end

  // Reset is not a bubble; the counter sticks at all-ones once reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != {CNTW{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + CNTW'(1);
    end
  end

  assign reg_write_e  = r_ctrl.reg_write;
  assign alu_src_e    = r_ctrl.alu_src;
  assign mem_write_e  = r_ctrl.mem_write;
  assign result_src_e = r_ctrl.result_src;
  assign branch_e     = r_ctrl.branch;
  assign alu_ctrl_e   = r_ctrl.alu_ctrl;
  assign valid_e      = r_valid;
  assign rd1_e        = r_rd1;
  assign rd2_e        = r_rd2;
  assign imm_ext_e    = r_imm_ext;
  assign pc_e         = r_pc;
  assign pc_plus4_e   = r_pc_plus4;
  assign rs1_e        = r_rs1;
  assign rs2_e        = r_rs2;
  assign rd_e         = r_rd;
  assign stall_f      = w_lw_stall;
  assign stall_d      = w_lw_stall;
  assign bubble_cnt   = r_bubble_cnt;

endmodule
